imem_loader: RTL
================

# imem_loader

Boot and load sequencer for the single-cycle core's 128-word instruction RAM. It accepts a stream of instruction words from a host over a valid/ready handshake and writes them to consecutive instruction RAM addresses starting at 0. While loading, it holds the core stopped by driving its `I_ready` low. Once the programmed word count has been written it releases the core, and it can later halt the core and reload on request.

## Interface
Parameters:
- `AW`, 7, instruction RAM word-address width.
- `DW`, 32, instruction word width.
- `DEPTH`, 128, instruction RAM depth in words (equals 2^AW).

Ports:
- `clk`  in  1  clock. Everything is clocked on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `start`  in  1  single-cycle pulse that begins or restarts a load.
- `load_len`  in  AW+1  number of words to load, sampled when `start` is high. 1..DEPTH; 0 means DEPTH.
- `s_valid`  in  1  host word valid.
- `s_data`  in  DW  host word, stored as-is with no byte swap.
- `s_ready`  out  1  loader ready for a host word.
- `imem_wen`  out  1  instruction RAM write enable, registered.
- `imem_addr`  out  AW  instruction RAM write address, registered.
- `imem_wdata`  out  DW  instruction RAM write data, registered.
- `core_run`  out  1  drives the core's `I_ready`. 1 lets the core run; 0 holds its PC at 0.
- `busy`  out  1  high in LOAD, CHK and SETTLE.
- `err`  out  1  checksum mismatch flag. Sticky until the next `start` or `rst`.
- `word_cnt`  out  AW+1  number of words accepted in the current load.

## Operation
- States: IDLE, LOAD, CHK (present only with the checksum feature), SETTLE, RUN, ERR.
- Reset:
  - State goes to IDLE.
  - Every output is 0: `s_ready`, `imem_wen`, `imem_addr`, `imem_wdata`, `core_run`, `busy`, `err`, `word_cnt`.
  - The core stays held until a load completes.
- IDLE:
  - `start` latches `len` = (`load_len`==0 ? DEPTH : `load_len`), clears `word_cnt` and `err`, and moves to LOAD.
- LOAD:
  - `s_ready` = ~`start`.
  - A beat is accepted when `s_valid` & `s_ready`.
  - Each accepted beat:
    - registers `imem_wen`=1, `imem_addr`=`word_cnt`[AW-1:0] and `imem_wdata`=`s_data` for the next cycle;
    - increments `word_cnt`.
  - On the beat where `word_cnt`+1 == `len`, the next state is CHK if the feature is on, otherwise SETTLE.
  - No write ever goes past address `len`-1. A length of DEPTH writes addresses 0..127 with no wrap.
- CHK:
  - `s_ready`=1. One extra beat is accepted.
  - If that beat equals the running sum, go to SETTLE. Otherwise set `err`=1 and go to ERR.
  - The check beat is never written to RAM.
- SETTLE:
  - Lasts one cycle, letting the final RAM write land.
  - `start` is ignored here.
  - Next state is RUN.
- RUN:
  - `core_run`=1 and `s_ready`=0.
  - `start` drops `core_run` on the next cycle and enters LOAD with the new length.
- ERR:
  - `core_run`=0 and `s_ready`=0.
  - Only `start` leaves this state, going to LOAD.
- `start` during LOAD or CHK aborts the current load:
  - `len` is re-latched and `word_cnt` is cleared.
  - The state stays in or returns to LOAD.
  - No beat is accepted in the `start` cycle.
  - Words already written remain in RAM.
- `s_valid` outside LOAD/CHK is ignored and produces no write.
- `s_data` may change while `s_valid` is low. A beat is held until it is accepted.

## Timing
- Write latency: a beat accepted in cycle N produces `imem_wen` high in cycle N+1. `imem_wen` is high for exactly one cycle per beat.
- Throughput: one word per cycle at most.
- Release latency, counting from the cycle N in which the last data beat is accepted:
  - without checksum: N+1 is SETTLE (the final write occurs), and `core_run`=1 from N+2;
  - with checksum: the check beat is accepted at M ≥ N+1, and `core_run`=1 from M+2.
- `busy` follows the registered state. `core_run` is registered and free of glitches.
- `rst` in any state returns to the reset values on the next edge. A write registered in the same edge as `rst` is cancelled (`imem_wen`=0).

## Configuration
- `IMEM_LOADER_CHKSUM_EN` defined:
  - The CHK state exists.
  - A DW-bit sum, modulo 2^DW, of all accepted data words is kept and cleared on `start`.
  - The host must send the sum as one extra beat after the last word.
  - `err` and the ERR state are reachable.
- `IMEM_LOADER_CHKSUM_EN` undefined:
  - No CHK state and no sum register.
  - LOAD goes directly to SETTLE.
  - `err` is tied to 0 and ERR is unreachable.

## Test plan
- Reset then idle: assert `rst` 2 cycles while `s_valid`=1. Every output stays 0 and no `imem_wen` pulse appears.
- Basic load: `start` with `load_len`=3, then words 0x00000013, 0x00100093, 0x00208113 sent back-to-back.
  - Writes land at addresses 0, 1, 2 in consecutive cycles.
  - `core_run` rises 2 cycles after the third beat and `word_cnt`=3.
- Full-depth load: `load_len`=0 with 128 words and random `s_valid` gaps.
  - Exactly 128 writes, the last at address 127.
  - `s_ready` drops after the last beat.
  - A 129th `s_valid` beat is not accepted.
- Abort and restart: `start` after 5 words with `load_len`=2.
  - No accept in the `start` cycle and `word_cnt` goes to 0.
  - The next two words overwrite addresses 0 and 1, then the core releases.
- Reload from RUN: `start` while `core_run`=1. `core_run` is 0 the next cycle, `busy`=1, and the new load proceeds.
- Checksum (with `IMEM_LOADER_CHKSUM_EN`):
  - Words 0x1, 0x2 followed by check beat 0x3: release, `err`=0.
  - Check beat 0x4: `err`=1, `core_run` stays 0, and 2 writes only. The following `start` clears `err`.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction RAM boot/load sequencer: streams host words into the instruction RAM and holds the core.
// Defining IMEM_LOADER_CHKSUM_EN adds a trailing checksum beat and the error path.
module imem_loader #(
    parameter int unsigned AW    = 7,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   load_len,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          imem_wen,
    output logic [AW-1:0] imem_addr,
    output logic [DW-1:0] imem_wdata,
    output logic          core_run,
    output logic          busy,
    output logic          err,
    output logic [AW:0]   word_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
`ifdef IMEM_LOADER_CHKSUM_EN
        StChk,
`endif
        StSettle,
        StRun,
        StErr
    } state_e;

    localparam logic [AW:0] CntOne   = (AW+1)'(1);
    localparam logic [AW:0] DepthLen = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          wen_d, run_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic          restart, beat;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [DW-1:0] sum_q, sum_d;
    logic          err_q, err_d;
`endif

    // start is honoured everywhere except the single settle cycle
    assign restart = start && (state_q != StSettle);

    always_comb begin
        s_ready = 1'b0;
        if (state_q == StLoad) s_ready = !start;
`ifdef IMEM_LOADER_CHKSUM_EN
        if (state_q == StChk) s_ready = !start;
`endif
    end

    assign beat = s_valid && s_ready;

`ifdef IMEM_LOADER_CHKSUM_EN
    assign busy = (state_q == StLoad) || (state_q == StChk) || (state_q == StSettle);
    assign err  = err_q;
`else
    assign busy = (state_q == StLoad) || (state_q == StSettle);
    assign err  = 1'b0;
`endif
    assign word_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wen_d   = 1'b0;
        addr_d  = imem_addr;
        wdata_d = imem_wdata;
`ifdef IMEM_LOADER_CHKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        if (restart) begin
            state_d = StLoad;
            len_d   = (load_len == '0) ? DepthLen : load_len;
            cnt_d   = '0;
`ifdef IMEM_LOADER_CHKSUM_EN
            sum_d   = '0;
            err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                StLoad: begin
                    if (beat) begin
                        wen_d   = 1'b1;
                        addr_d  = cnt_q[AW-1:0];
                        wdata_d = s_data;
                        cnt_d   = cnt_q + CntOne;
`ifdef IMEM_LOADER_CHKSUM_EN
                        sum_d   = sum_q + s_data;
                        if (cnt_q + CntOne == len_q) state_d = StChk;
`else
                        if (cnt_q + CntOne == len_q) state_d = StSettle;
`endif
                    end
                end
`ifdef IMEM_LOADER_CHKSUM_EN
                // check beat is compared only, never written
                StChk: begin
                    if (beat) begin
                        if (s_data == sum_q) begin
                            state_d = StSettle;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StErr;
                        end
                    end
                end
`endif
                StSettle: state_d = StRun;
                default: ;
            endcase
        end
        run_d = (state_d == StRun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            cnt_q      <= '0;
            imem_wen   <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_run   <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            imem_wen   <= wen_d;
            imem_addr  <= addr_d;
            imem_wdata <= wdata_d;
            core_run   <= run_d;
`ifdef IMEM_LOADER_CHKSUM_EN
            sum_q      <= sum_d;
            err_q      <= err_d;
`endif
        end
    end

endmodule
